pu_fifo: RTL and testbench
==========================

Name: pu_fifo

Overview:
- Buffering process unit on the same bus as the other PUs.
- Queues words written from the bus and replays them in FIFO order when output is enabled.
- Consumes the registered data/attr produced by an upstream PU and re-drives them for a downstream PU.
- When not enabled, drives all zeros so its output can be OR-merged onto the shared bus.

Parameters:
- DATA_WIDTH, 32, width of data word
- ATTR_WIDTH, 4, width of attribute word; bit 0 is the INVALID flag
- DEPTH, 8, queue depth in entries; legal range 2..256, any integer

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- signal_wr  input  1  push data_in/attr_in this cycle
- data_in  input  DATA_WIDTH  word to enqueue
- attr_in  input  ATTR_WIDTH  attribute to enqueue with the word
- signal_oe  input  1  pop head entry and drive it to the bus
- data_out  output  DATA_WIDTH  registered popped data; 0 when not popping
- attr_out  output  ATTR_WIDTH  registered popped attribute; 0 when not popping
- count  output  $clog2(DEPTH+1)  current occupancy
- empty  output  1  count == 0
- full  output  1  count == DEPTH

Behaviour:
- Reset (async, rst_n low):
  - wr_ptr, rd_ptr, count and the sticky error flags go to 0.
  - data_out = 0, attr_out = 0, empty = 1, full = 0.
  - Storage contents are not reset.
  - Reset mid-operation discards all queued entries immediately, without waiting for a clock edge.
- Push: on a clk edge with signal_wr = 1 and not full:
  - mem[wr_ptr] <= {attr_in, data_in}.
  - wr_ptr advances by 1, wrapping DEPTH-1 -> 0.
  - count increments.
- Pop: on a clk edge with signal_oe = 1 and not empty:
  - {attr_out, data_out} <= mem[rd_ptr].
  - rd_ptr advances with the same wrap rule.
  - count decrements.
- Latency:
  - A popped word appears on data_out/attr_out in the cycle after the edge where signal_oe was sampled.
  - It is held for exactly one cycle.
  - A word pushed at edge N is poppable at edge N+1 or later; no same-edge bypass.
- Idle: on any edge with signal_oe = 0, {attr_out, data_out} <= 0.
- Underflow: signal_oe = 1 while empty:
  - Pointers and count are unchanged.
  - data_out <= 0; attr_out <= 0 with only bit 0 (INVALID) set.
- Overflow: signal_wr = 1 while full and signal_oe = 0:
  - The write is dropped; pointers and count are unchanged.
- Simultaneous push and pop:
  - Not empty (including full): both succeed, count unchanged, popped word is the old head.
  - Empty: the push succeeds, the pop underflows as above, count becomes 1.
- Status: count, empty and full are registered, derived from the next-state count, and valid the cycle after each edge.
- Storage is inferred RAM or a register array; the read is registered into data_out.

Optional Feature:
- Macro: PU_FIFO_STICKY_ERR_EN.
- Defined:
  - Internal sticky flag err is set by any underflow or overflow event.
  - err is cleared only by reset.
  - While err = 1, every non-zero output cycle (pop or underflow) forces attr_out bit 0 = 1, marking all later results INVALID.
  - Extra output port err (1 bit), reset 0.
- Undefined:
  - No err port.
  - Only the underflow cycle itself carries INVALID.
  - Overflow is silent apart from the dropped write.

Test Plan:
- Reset then idle 3 cycles:
  - data_out = 0, attr_out = 0, empty = 1, full = 0, count = 0 throughout.
- Push 0x11, 0x22, 0x33 (attr 0x2, 0x0, 0x4), then oe for 3 cycles:
  - data_out 0x11/0x22/0x33 with attr 0x2/0x0/0x4 on the cycles after each oe edge.
  - Zeros after the last pop; empty = 1.
- DEPTH = 8: push 10 words 1..10, then pop 8:
  - full after the 8th push; words 9 and 10 dropped.
  - Pops return 1..8; pointers wrap correctly on a second fill of 8.
- oe while empty:
  - data_out = 0, attr_out = 0x1 for one cycle; count stays 0.
  - With PU_FIFO_STICKY_ERR_EN, err = 1 and a later pop of 0x55 with attr 0x0 yields attr_out = 0x1.
- Full queue, wr = 0xAA and oe on the same edge:
  - Head popped, 0xAA enqueued, count stays 8, full stays 1.
  - 0xAA emerges as the 8th subsequent pop.
- Assert rst_n low mid-cycle with 5 entries queued:
  - Outputs 0, count 0, empty 1 immediately, before the next clk edge.
  - A subsequent push/pop of 0x77 returns 0x77.

Source files
------------

// File: rtl/pu_fifo.sv
// pu_fifo: bus process unit that queues words and replays them in FIFO order.
// Optional sticky error reporting is enabled by defining PU_FIFO_STICKY_ERR_EN.
module pu_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       signal_wr,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [ATTR_WIDTH-1:0]      attr_in,
  input  logic                       signal_oe,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [ATTR_WIDTH-1:0]      attr_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
`ifdef PU_FIFO_STICKY_ERR_EN
  output logic                       full,
  output logic                       err
`else
  output logic                       full
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = ATTR_WIDTH + DATA_WIDTH;
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [EW-1:0]         mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  empty_r;
  logic                  full_r;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic [ATTR_WIDTH-1:0] attr_out_r;
  logic                  err_r;

  logic                  push_s;
  logic                  pop_s;
  logic                  underflow_s;
  logic                  overflow_s;
  logic [CW-1:0]         count_nxt_s;
  logic [EW-1:0]         rd_word_s;
  logic [DATA_WIDTH-1:0] data_nxt_s;
  logic [ATTR_WIDTH-1:0] attr_nxt_s;

  // Wrapping pointer increment; DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    logic [AW-1:0] r;
    if (p == LAST_PTR) begin
      r = {AW{1'b0}};
    end else begin
      r = p + AW'(1'b1);
    end
    return r;
  endfunction

  // Push/pop qualification, next occupancy and next output word.
  always_comb begin
    push_s      = signal_wr & ((count_r != DEPTH_CNT) | signal_oe);
    pop_s       = signal_oe & (count_r != {CW{1'b0}});
    underflow_s = signal_oe & (count_r == {CW{1'b0}});
    overflow_s  = signal_wr & (count_r == DEPTH_CNT) & ~signal_oe;
    rd_word_s   = mem_r[rd_ptr_r];
    data_nxt_s  = {DATA_WIDTH{1'b0}};
    attr_nxt_s  = {ATTR_WIDTH{1'b0}};
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      data_nxt_s = rd_word_s[DATA_WIDTH-1:0];
      attr_nxt_s = rd_word_s[EW-1:DATA_WIDTH];
    end else if (underflow_s) begin
      attr_nxt_s = ATTR_WIDTH'(1'b1);
    end else begin
      attr_nxt_s = {ATTR_WIDTH{1'b0}};
    end
    // A latched error poisons every later non-idle result.
    attr_nxt_s[0] = attr_nxt_s[0] | (err_r & signal_oe);
  end

  // Pointers, occupancy, status and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      data_out_r <= {DATA_WIDTH{1'b0}};
      attr_out_r <= {ATTR_WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r    <= count_nxt_s;
      empty_r    <= (count_nxt_s == {CW{1'b0}});
      full_r     <= (count_nxt_s == DEPTH_CNT);
      data_out_r <= data_nxt_s;
      attr_out_r <= attr_nxt_s;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {attr_in, data_in};
    end
  end

`ifdef PU_FIFO_STICKY_ERR_EN
  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | underflow_s | overflow_s;
    end
  end

  assign err = err_r;
`else
  assign err_r = 1'b0;
`endif

  assign data_out = data_out_r;
  assign attr_out = attr_out_r;
  assign count    = count_r;
  assign empty    = empty_r;
  assign full     = full_r;

endmodule

// File: tb/tb_pu_fifo.sv
// Self-checking bench for pu_fifo: randomized stimulus against a queue-based model.
module tb_pu_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OW    = DW + AW + CW + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          signal_wr = 1'b0;
  logic          signal_oe = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [AW-1:0] attr_in = '0;
  logic [DW-1:0] data_out;
  logic [AW-1:0] attr_out;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          err_bit;

  pu_fifo #(.DATA_WIDTH(DW), .ATTR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .signal_wr(signal_wr), .data_in(data_in),
    .attr_in(attr_in), .signal_oe(signal_oe), .data_out(data_out),
    .attr_out(attr_out), .count(count), .empty(empty),
`ifdef PU_FIFO_STICKY_ERR_EN
    .full(full), .err(err_bit)
`else
    .full(full)
`endif
  );
`ifndef PU_FIFO_STICKY_ERR_EN
  assign err_bit = 1'b0;
`endif

  always #5 clk = ~clk;

  wire [OW-1:0] obs_s = {data_out, attr_out, count, empty, full, err_bit};
  localparam logic [OW-1:0] RESET_V = {{(DW+AW+CW){1'b0}}, 1'b1, 1'b0, 1'b0};

  logic [DW+AW-1:0] q[$];
  bit               err_m;
  logic [OW-1:0]    exp_v;
  int               n_tests = 0;
  int               n_fail = 0;

  // Apply one cycle of stimulus, then advance the model to what the DUT shows after the edge.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic [AW-1:0] a, input logic oe);
    int pre;
    logic [DW-1:0] od;
    logic [AW-1:0] oa;
    bit under, over;
    signal_wr = wr; data_in = d; attr_in = a; signal_oe = oe;
    @(posedge clk); #1;
    pre = q.size(); od = '0; oa = '0; under = 0; over = 0;
    if (oe) begin
      if (pre > 0) {oa, od} = q.pop_front();
      else begin oa = 4'h1; under = 1; end
      if (err_m) oa[0] = 1'b1;
    end
    if (wr) begin
      if (pre < DEPTH || oe) q.push_back({a, d});
      else over = 1;
    end
`ifdef PU_FIFO_STICKY_ERR_EN
    err_m = err_m | under | over;
`endif
    exp_v = {od, oa, CW'(q.size()), q.size() == 0, q.size() == DEPTH, err_m};
    signal_wr = 1'b0; signal_oe = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (obs_s !== RESET_V) begin n_fail++; $display("FAIL reset: got %h want %h", obs_s, RESET_V); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b0);
      n_tests++;
      if (obs_s !== RESET_V) begin n_fail++; $display("FAIL reset_idle[%0d]: got %h want %h", i, obs_s, RESET_V); end
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] dv [3] = '{32'h11, 32'h22, 32'h33};
    logic [AW-1:0] av [3] = '{4'h2, 4'h0, 4'h4};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, dv[i], av[i], 1'b0);
      n_tests++;
      if (obs_s !== exp_v) begin n_fail++; $display("FAIL basic_push[%0d]: got %h want %h", i, obs_s, exp_v); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b1);
      n_tests++;
      if (obs_s !== exp_v || data_out !== dv[i] || attr_out !== av[i]) begin
        n_fail++; $display("FAIL basic_pop[%0d]: got %h want %h", i, obs_s, exp_v);
      end
    end
    step(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (obs_s !== exp_v || empty !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got %h want %h", obs_s, exp_v); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, DW'(i), '0, 1'b0);
      n_tests++;
      if (obs_s !== exp_v) begin n_fail++; $display("FAIL ovf_push[%0d]: got %h want %h", i, obs_s, exp_v); end
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, '0, 1'b1);
      n_tests++;
      if (obs_s !== exp_v || data_out !== DW'(i)) begin n_fail++; $display("FAIL ovf_pop[%0d]: got %h want %h", i, obs_s, exp_v); end
    end
    for (int i = 0; i < 16; i++) begin
      step(i < 8, $urandom, AW'($urandom), i >= 8);
      n_tests++;
      if (obs_s !== exp_v) begin n_fail++; $display("FAIL wrap[%0d]: got %h want %h", i, obs_s, exp_v); end
    end
  endtask

  task automatic test_underflow();
    step(1'b0, '0, '0, 1'b1);
    n_tests++;
    if (obs_s !== exp_v || attr_out !== 4'h1 || count !== '0) begin n_fail++; $display("FAIL underflow: got %h want %h", obs_s, exp_v); end
    step(1'b0, '0, '0, 1'b0);
    n_tests++;
    if (obs_s !== exp_v) begin n_fail++; $display("FAIL underflow_hold: got %h want %h", obs_s, exp_v); end
    step(1'b1, 32'h55, 4'h0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    n_tests++;
    if (obs_s !== exp_v || data_out !== 32'h55) begin n_fail++; $display("FAIL after_underflow: got %h want %h", obs_s, exp_v); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, AW'($urandom), 1'b0);
    step(1'b1, 32'hAA, 4'h0, 1'b1);
    n_tests++;
    if (obs_s !== exp_v || full !== 1'b1) begin n_fail++; $display("FAIL simul_full: got %h want %h", obs_s, exp_v); end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, '0, 1'b1);
      n_tests++;
      if (obs_s !== exp_v) begin n_fail++; $display("FAIL simul_drain[%0d]: got %h want %h", i, obs_s, exp_v); end
    end
    n_tests++;
    if (data_out !== 32'hAA) begin n_fail++; $display("FAIL simul_last: got %h want %h", data_out, 32'hAA); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, AW'($urandom), 1'($urandom_range(0, 1)));
      n_tests++;
      if (obs_s !== exp_v) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", i, obs_s, exp_v); end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) step(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, DW'($urandom) | 32'h1, AW'($urandom), 1'b0);
    step(1'b0, '0, '0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs_s !== RESET_V) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs_s, RESET_V); end
    q.delete();
    err_m = 0;
    rst_n = 1'b1;
    step(1'b1, 32'h77, 4'h0, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    n_tests++;
    if (obs_s !== exp_v || data_out !== 32'h77) begin n_fail++; $display("FAIL post_reset: got %h want %h", obs_s, exp_v); end
  endtask

  initial begin
    err_m = 0;
    test_reset();
    test_basic();
    test_underflow();
    test_overflow();
    test_full_simul();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
